// File: rtl/nibble_serializer_pkg.sv
// nibble_serializer_pkg: output-stage state encoding, nibble width and nibble select helper
package nibble_serializer_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    function automatic logic [NIB_W-1:0] nib_sel(input logic [7:0] b, input logic hi);
        return hi ? b[7:4] : b[3:0];
    endfunction

endpackage

// File: rtl/nibble_serializer_fifo.sv
// byte_fifo_sync: byte FIFO with registered storage and a combinational head output
module byte_fifo_sync #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] fill
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    // a pop never frees a slot for a same-cycle write, so full refuses outright
    assign full    = fill == (AW+1)'(DEPTH);
    assign empty   = fill == '0;
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            wr_ptr <= wr_ok ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= rd_ok ? rd_ptr + AW'(1) : rd_ptr;
            fill   <= fill + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end

endmodule

// File: rtl/nibble_serializer.sv
// nibble_serializer: buffers bytes in a FIFO and emits each as two 4-bit nibbles
module nibble_serializer
    import nibble_serializer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [NIB_W-1:0]       out_nibble,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [$clog2(DEPTH):0] fill
);

    state_t     state;
    logic [7:0] head;
    logic [7:0] hold;
    logic       full;
    logic       empty;
    logic       load;

    assign in_ready = !full;
    // reload straight from SECOND keeps consecutive bytes bubble-free
    assign load = !empty && (state == IDLE || (state == SECOND && out_ready));

    byte_fifo_sync #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_byte),
        .rd_en   (load),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .fill    (fill)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            hold       <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_nibble <= '0;
        end else if (load) begin
            state      <= FIRST;
            hold       <= head;
            out_valid  <= 1'b1;
            out_last   <= 1'b0;
            out_nibble <= nib_sel(head, !LOW_FIRST);
        end else if (state == FIRST && out_ready) begin
            state      <= SECOND;
            out_last   <= 1'b1;
            out_nibble <= nib_sel(hold, LOW_FIRST);
        end else if (state == SECOND && out_ready) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_nibble <= '0;
        end

endmodule

// File: tb/tb_nibble_serializer.sv
// tb_nibble_serializer: directed checks on low-first and high-first instances driven in lockstep
module tb_nibble_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_byte = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       lo_ir, hi_ir, lo_v, hi_v, lo_l, hi_l;
    logic [3:0] lo_n, hi_n;
    logic [2:0] lo_f, hi_f;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    nibble_serializer #(.DEPTH(4), .LOW_FIRST(1'b1)) u_lo (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(lo_ir),
        .out_nibble(lo_n), .out_valid(lo_v), .out_ready(out_ready), .out_last(lo_l), .fill(lo_f)
    );

    nibble_serializer #(.DEPTH(4), .LOW_FIRST(1'b0)) u_hi (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(hi_ir),
        .out_nibble(hi_n), .out_valid(hi_v), .out_ready(out_ready), .out_last(hi_l), .fill(hi_f)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_nib(input string tag, input logic [7:0] b, input bit half);
        chk({tag, "_lo_valid"}, 8'(lo_v), 8'd1);
        chk({tag, "_hi_valid"}, 8'(hi_v), 8'd1);
        chk({tag, "_lo_nib"}, 8'(lo_n), half ? 8'(b[7:4]) : 8'(b[3:0]));
        chk({tag, "_hi_nib"}, 8'(hi_n), half ? 8'(b[3:0]) : 8'(b[7:4]));
        chk({tag, "_lo_last"}, 8'(lo_l), 8'(half));
        chk({tag, "_hi_last"}, 8'(hi_l), 8'(half));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_lo_valid"}, 8'(lo_v), 8'd0);
        chk({tag, "_hi_valid"}, 8'(hi_v), 8'd0);
        chk({tag, "_lo_fill"}, 8'(lo_f), 8'd0);
        chk({tag, "_hi_fill"}, 8'(hi_f), 8'd0);
        chk({tag, "_lo_ready"}, 8'(lo_ir), 8'd1);
        chk({tag, "_hi_ready"}, 8'(hi_ir), 8'd1);
    endtask

    initial begin
        logic [7:0] b3 [3];
        logic [7:0] sb [$];
        int         sent;
        int         got;
        bit         half;
        bit         hold_prev;
        bit         push;
        logic [3:0] p_lo_n, p_hi_n;
        logic       p_lo_l;

        repeat (2) cycle();
        chk_idle("reset");
        chk("reset_lo_nib", 8'(lo_n), 8'd0);
        chk("reset_lo_last", 8'(lo_l), 8'd0);
        rst = 1'b0;
        cycle();

        // single byte, latency and order
        in_byte = 8'hA5;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("t1_fill1", 8'(lo_f), 8'd1);
        chk("t1_nov", 8'(lo_v), 8'd0);
        cycle();
        chk_nib("t1_first", 8'hA5, 1'b0);
        chk("t1_fill0", 8'(lo_f), 8'd0);
        cycle();
        chk_nib("t1_second", 8'hA5, 1'b1);
        cycle();
        chk_idle("t1_end");

        // back-to-back bytes, no bubbles
        b3[0] = 8'h12;
        b3[1] = 8'h34;
        b3[2] = 8'h56;
        for (int i = 0; i < 8; i++) begin
            in_valid = i < 3;
            in_byte = i < 3 ? b3[i] : 8'h00;
            cycle();
            if (i >= 1 && i <= 6) chk_nib("t2_stream", b3[(i-1)/2], 1'((i-1)%2));
        end
        chk_idle("t2_end");

        // backpressure fills the FIFO, then full-with-pop refuses the write
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_byte = 8'(i);
            in_valid = 1'b1;
            cycle();
        end
        chk("t3_lo_full_ready", 8'(lo_ir), 8'd0);
        chk("t3_hi_full_ready", 8'(hi_ir), 8'd0);
        chk("t3_fill4", 8'(lo_f), 8'd4);
        chk_nib("t3_hold", 8'h01, 1'b0);
        repeat (2) cycle();
        chk_nib("t3_still", 8'h01, 1'b0);
        chk("t3_still_fill", 8'(lo_f), 8'd4);
        out_ready = 1'b1;
        cycle();
        chk_nib("t3_b1_second", 8'h01, 1'b1);
        chk("t3_a_fill", 8'(lo_f), 8'd4);
        chk("t3_a_ready", 8'(lo_ir), 8'd0);
        cycle();
        chk_nib("t3_b2_first", 8'h02, 1'b0);
        chk("t3_refused_fill", 8'(lo_f), 8'd3);
        chk("t3_refused_ready", 8'(lo_ir), 8'd1);
        cycle();
        in_valid = 1'b0;
        chk_nib("t3_b2_second", 8'h02, 1'b1);
        chk("t3_accept_fill", 8'(hi_f), 8'd4);
        for (int j = 0; j < 8; j++) begin
            cycle();
            chk_nib("t3_drain", 8'(3 + j/2), 1'(j%2));
        end
        cycle();
        chk_idle("t3_end");

        // reset while in SECOND with two bytes queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_byte = 8'hAA + 8'(i * 17);
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("t5_in_second", 8'(lo_l), 8'd1);
        chk("t5_fill2", 8'(lo_f), 8'd2);
        #2 rst = 1'b1;
        #1;
        chk_idle("t5_async");
        chk("t5_nib0", 8'(lo_n), 8'd0);
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        in_byte = 8'hC3;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk_nib("t5_c3_first", 8'hC3, 1'b0);
        cycle();
        chk_nib("t5_c3_second", 8'hC3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t5_quiet", 8'(lo_v), 8'd0);
        end

        // random backpressure scoreboard
        sent = 0;
        got = 0;
        half = 1'b0;
        hold_prev = 1'b0;
        p_lo_n = '0;
        p_hi_n = '0;
        p_lo_l = 1'b0;
        for (int cyc = 0; cyc < 6000 && got < 200; cyc++) begin
            if (!in_valid && sent < 200 && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                in_byte = 8'($urandom);
            end
            out_ready = $urandom_range(0, 2) != 0;
            if (hold_prev) begin
                chk("t4_stable_valid", 8'(lo_v), 8'd1);
                chk("t4_stable_lo_nib", 8'(lo_n), 8'(p_lo_n));
                chk("t4_stable_hi_nib", 8'(hi_n), 8'(p_hi_n));
                chk("t4_stable_last", 8'(lo_l), 8'(p_lo_l));
            end
            if (lo_v && out_ready) begin
                chk_nib("t4_nib", sb.size() > 0 ? sb[0] : 8'hxx, half);
                if (half) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    got++;
                end
                half = !half;
            end
            hold_prev = lo_v && !out_ready;
            p_lo_n = lo_n;
            p_hi_n = hi_n;
            p_lo_l = lo_l;
            push = in_valid && lo_ir;
            cycle();
            if (push) begin
                sb.push_back(in_byte);
                sent++;
                in_valid = 1'b0;
            end
        end
        chk("t4_all_bytes", 8'(got), 8'd200);
        chk("t4_sb_empty", 8'(sb.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
